// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared state encoding, default timing and helpers for the ADC scan controller
package adc_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_PWRUP   = 3'd1,
    ST_IDLE    = 3'd2,
    ST_SAMPLE  = 3'd3,
    ST_CONVERT = 3'd4,
    ST_STORE   = 3'd5
  } adc_state_e;

  localparam int DEF_ADC_WIDTH     = 12;
  localparam int DEF_NUM_CH        = 4;
  localparam int DEF_PWRUP_CYCLES  = 16;
  localparam int DEF_SAMPLE_CYCLES = 8;
  localparam int DEF_BIT_CYCLES    = 2;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Priority search: index of the lowest set bit, 0 when the mask is empty.
  function automatic int lowest_set(input logic [31:0] m);
    int idx;
    idx = 0;
    for (int i = 31; i >= 0; i--) begin
      if (m[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/adc_scan_ctrl_if.sv
// rtl/adc_scan_ctrl_if.sv - control, analog front-end and result signals of the scan controller
interface adc_scan_ctrl_if import adc_pkg::*; #(
  parameter int ADC_WIDTH = DEF_ADC_WIDTH,
  parameter int NUM_CH    = DEF_NUM_CH
);
  localparam int CH_W = ch_width(NUM_CH);

  logic                 en;
  logic                 start;
  logic                 auto;
  logic [NUM_CH-1:0]    ch_mask;
  logic                 comparator;
  logic [ADC_WIDTH-1:0] dac;
  logic                 sample_and_hold;
  logic                 pwr_gate;
  logic                 dac_rst;
  logic [CH_W-1:0]      ch_sel;
  logic                 busy;
  logic                 ready;
  logic                 done;
  logic [ADC_WIDTH-1:0] result;
  logic [CH_W-1:0]      result_ch;

  modport master (
    output en, start, auto, ch_mask, comparator,
    input  dac, sample_and_hold, pwr_gate, dac_rst, ch_sel,
    input  busy, ready, done, result, result_ch
  );

  modport slave (
    input  en, start, auto, ch_mask, comparator,
    output dac, sample_and_hold, pwr_gate, dac_rst, ch_sel,
    output busy, ready, done, result, result_ch
  );

endinterface

// File: rtl/sar_core.sv
// rtl/sar_core.sv - successive-approximation bit-trial register, MSB first
module sar_core #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             comp,
  output logic [WIDTH-1:0] trial,
  output logic [WIDTH-1:0] final_code,
  output logic             last_bit
);

  logic [WIDTH-1:0] kept_q, kept_d;
  logic [WIDTH-1:0] bit_q, bit_d;

  // Kept bits with the current trial bit resolved by the comparator.
  assign final_code = comp ? (kept_q | bit_q) : kept_q;
  assign trial      = kept_q | bit_q;
  assign last_bit   = bit_q[0];

  always_comb begin
    kept_d = kept_q;
    bit_d  = bit_q;
    if (load) begin
      kept_d = '0;
      bit_d  = {1'b1, {(WIDTH-1){1'b0}}};
    end else if (step) begin
      kept_d = final_code;
      bit_d  = bit_q >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kept_q <= '0;
      bit_q  <= '0;
    end else begin
      kept_q <= kept_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/adc_scan_ctrl.sv
// rtl/adc_scan_ctrl.sv - multi-channel SAR ADC sequencer: power-up, channel scan, track, convert, store
module adc_scan_ctrl import adc_pkg::*; #(
  parameter int ADC_WIDTH     = DEF_ADC_WIDTH,
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int PWRUP_CYCLES  = DEF_PWRUP_CYCLES,
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
  parameter int BIT_CYCLES    = DEF_BIT_CYCLES
) (
  input  logic            sys_clk,
  input  logic            reset,
  adc_scan_ctrl_if.slave  bus
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int CNT_W = 16;

  adc_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_CH-1:0]    rem_q, rem_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [ADC_WIDTH-1:0] result_q, result_d;
  logic [CH_W-1:0]      result_ch_q, result_ch_d;

  logic                 sar_load;
  logic                 sar_step;
  logic                 sar_last;
  logic [ADC_WIDTH-1:0] sar_trial;
  logic [ADC_WIDTH-1:0] sar_final;
  logic [NUM_CH-1:0]    rem_clr;

  logic [ADC_WIDTH-1:0] dac_o;
  logic                 sh_o;
  logic                 pwr_o;
  logic                 dac_rst_o;
  logic                 busy_o;
  logic                 ready_o;
  logic                 done_o;

  // Remaining mask once the channel just stored has been retired.
  assign rem_clr  = rem_q & ~(NUM_CH'(1) << ch_q);
  assign sar_load = (state_q == ST_SAMPLE);
  assign sar_step = (state_q == ST_CONVERT) && (cnt_q == CNT_W'(BIT_CYCLES - 1));

  sar_core #(
    .WIDTH (ADC_WIDTH)
  ) u_sar (
    .clk        (sys_clk),
    .rst        (reset),
    .load       (sar_load),
    .step       (sar_step),
    .comp       (bus.comparator),
    .trial      (sar_trial),
    .final_code (sar_final),
    .last_bit   (sar_last)
  );

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      rem_q       <= '0;
      ch_q        <= '0;
      result_q    <= '0;
      result_ch_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      ch_q        <= ch_d;
      result_q    <= result_d;
      result_ch_q <= result_ch_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    ch_d        = ch_q;
    result_d    = result_q;
    result_ch_d = result_ch_q;
    // Dropping enable wins over every transition, so a conversion in flight never stores.
    if (!bus.en) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      rem_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_PWRUP;
          cnt_d   = '0;
        end
        ST_PWRUP: begin
          if (cnt_q == CNT_W'(PWRUP_CYCLES - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_IDLE: begin
          if (bus.start && (|bus.ch_mask)) begin
            state_d = ST_SAMPLE;
            cnt_d   = '0;
            rem_d   = bus.ch_mask;
            ch_d    = CH_W'(lowest_set(32'(bus.ch_mask)));
          end
        end
        ST_SAMPLE: begin
          if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
            state_d = ST_CONVERT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_CONVERT: begin
          if (sar_step) begin
            cnt_d = '0;
            if (sar_last) begin
              state_d     = ST_STORE;
              result_d    = sar_final;
              result_ch_d = ch_q;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STORE: begin
          cnt_d = '0;
          if (|rem_clr) begin
            state_d = ST_SAMPLE;
            rem_d   = rem_clr;
            ch_d    = CH_W'(lowest_set(32'(rem_clr)));
          end else if (bus.auto && (|bus.ch_mask)) begin
            state_d = ST_SAMPLE;
            rem_d   = bus.ch_mask;
            ch_d    = CH_W'(lowest_set(32'(bus.ch_mask)));
          end else begin
            state_d = ST_IDLE;
            rem_d   = '0;
          end
        end
        default: begin
          state_d = ST_OFF;
          cnt_d   = '0;
          rem_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    dac_o     = '0;
    sh_o      = 1'b0;
    pwr_o     = 1'b1;
    dac_rst_o = 1'b1;
    busy_o    = 1'b0;
    ready_o   = 1'b0;
    done_o    = 1'b0;
    case (state_q)
      ST_OFF:     pwr_o = 1'b0;
      ST_PWRUP:   ;
      ST_IDLE:    ready_o = 1'b1;
      ST_SAMPLE: begin
        sh_o   = 1'b1;
        busy_o = 1'b1;
      end
      ST_CONVERT: begin
        dac_o     = sar_trial;
        dac_rst_o = 1'b0;
        busy_o    = 1'b1;
      end
      ST_STORE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default:    pwr_o = 1'b0;
    endcase
  end

  assign bus.dac             = dac_o;
  assign bus.sample_and_hold = sh_o;
  assign bus.pwr_gate        = pwr_o;
  assign bus.dac_rst         = dac_rst_o;
  assign bus.busy            = busy_o;
  assign bus.ready           = ready_o;
  assign bus.done            = done_o;
  assign bus.ch_sel          = ch_q;
  assign bus.result          = result_q;
  assign bus.result_ch       = result_ch_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb/tb_adc_scan_ctrl.sv - directed self-checking bench for adc_scan_ctrl with a per-channel comparator model
module tb_adc_scan_ctrl;

  localparam int W = 12;
  localparam int N = 4;

  logic         sys_clk = 1'b0;
  logic         reset   = 1'b1;
  int           checks  = 0;
  int           errors  = 0;
  int           done_cnt = 0;
  logic [W-1:0] vin [N];
  logic [W-1:0] dac_prev;

  adc_scan_ctrl_if #(.ADC_WIDTH(W), .NUM_CH(N)) bus ();

  adc_scan_ctrl #(
    .ADC_WIDTH     (W),
    .NUM_CH        (N),
    .PWRUP_CYCLES  (16),
    .SAMPLE_CYCLES (8),
    .BIT_CYCLES    (2)
  ) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  // Comparator answers Vin >= DAC, but is inverted on the first cycle of every new trial code.
  always @(posedge sys_clk) dac_prev <= bus.dac;
  assign bus.comparator = (vin[bus.ch_sel] >= bus.dac) ^ (bus.dac != dac_prev);

  always @(negedge sys_clk) if (bus.done) done_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic pulse_start(input logic [N-1:0] mask);
    bus.ch_mask = mask;
    bus.start   = 1'b1;
    cyc(1);
    bus.start   = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      cyc(1);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    cyc(2);
    checks++; if ({bus.pwr_gate, bus.dac_rst, bus.ready, bus.busy, bus.done, bus.sample_and_hold} !== 6'b010000) begin errors++; $display("FAIL reset_ctrl: got %b expected 010000", {bus.pwr_gate, bus.dac_rst, bus.ready, bus.busy, bus.done, bus.sample_and_hold}); end
    checks++; if (bus.dac !== 12'h000) begin errors++; $display("FAIL reset_dac: got %h expected 000", bus.dac); end
    checks++; if ({bus.result, bus.result_ch, bus.ch_sel} !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h expected 0000", {bus.result, bus.result_ch, bus.ch_sel}); end
    reset = 1'b0;
    cyc(3);
    checks++; if ({bus.pwr_gate, bus.ready} !== 2'b00) begin errors++; $display("FAIL off_hold: got %b expected 00", {bus.pwr_gate, bus.ready}); end
  endtask

  task automatic test_powerup;
    bus.en = 1'b1;
    cyc(1);
    checks++; if ({bus.pwr_gate, bus.dac_rst, bus.ready} !== 3'b110) begin errors++; $display("FAIL pwrup_entry: got %b expected 110", {bus.pwr_gate, bus.dac_rst, bus.ready}); end
    cyc(15);
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL pwrup_early_ready: got %b expected 0", bus.ready); end
    cyc(1);
    checks++; if ({bus.ready, bus.busy} !== 2'b10) begin errors++; $display("FAIL pwrup_ready: got %b expected 10", {bus.ready, bus.busy}); end
  endtask

  task automatic test_single;
    vin[0] = 12'hA52;
    pulse_start(4'b0001);
    checks++; if ({bus.busy, bus.sample_and_hold, bus.dac_rst, bus.ready} !== 4'b1110) begin errors++; $display("FAIL sample_ctrl: got %b expected 1110", {bus.busy, bus.sample_and_hold, bus.dac_rst, bus.ready}); end
    checks++; if ({bus.ch_sel, bus.dac} !== 14'h0000) begin errors++; $display("FAIL sample_ch_dac: got %h expected 0000", {bus.ch_sel, bus.dac}); end
    cyc(31);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL latency_early: got done=%b expected 0", bus.done); end
    cyc(1);
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL latency_done: got done=%b expected 1", bus.done); end
    checks++; if ({bus.result_ch, bus.result} !== 14'h0A52) begin errors++; $display("FAIL single_result: got ch=%0d res=%h expected ch=0 res=a52", bus.result_ch, bus.result); end
    cyc(1);
    checks++; if ({bus.ready, bus.done, bus.busy} !== 3'b100) begin errors++; $display("FAIL single_idle: got %b expected 100", {bus.ready, bus.done, bus.busy}); end
  endtask

  task automatic test_boundary;
    logic [W-1:0] codes [2];
    bit seen;
    codes[0] = 12'hFFF;
    codes[1] = 12'h000;
    for (int i = 0; i < 2; i++) begin
      vin[0] = codes[i];
      pulse_start(4'b0001);
      wait_done(40, seen);
      checks++; if (!seen) begin errors++; $display("FAIL boundary_timeout: got no done expected done for code %h", codes[i]); end
      checks++; if (bus.result !== codes[i]) begin errors++; $display("FAIL boundary_result: got %h expected %h", bus.result, codes[i]); end
      cyc(1);
    end
  endtask

  task automatic test_multi;
    bit seen;
    vin[1] = 12'h3C7;
    vin[3] = 12'h81E;
    bus.auto = 1'b0;
    pulse_start(4'b1010);
    checks++; if ({bus.ch_sel, bus.sample_and_hold} !== 3'b011) begin errors++; $display("FAIL multi_sel1: got ch=%0d sh=%b expected ch=1 sh=1", bus.ch_sel, bus.sample_and_hold); end
    wait_done(40, seen);
    checks++; if (!seen || {bus.result_ch, bus.result} !== 14'h13C7) begin errors++; $display("FAIL multi_res1: got seen=%b ch=%0d res=%h expected ch=1 res=3c7", seen, bus.result_ch, bus.result); end
    cyc(1);
    checks++; if ({bus.ch_sel, bus.sample_and_hold} !== 3'b111) begin errors++; $display("FAIL multi_sel3: got ch=%0d sh=%b expected ch=3 sh=1", bus.ch_sel, bus.sample_and_hold); end
    wait_done(40, seen);
    checks++; if (!seen || {bus.result_ch, bus.result} !== 14'h381E) begin errors++; $display("FAIL multi_res3: got seen=%b ch=%0d res=%h expected ch=3 res=81e", seen, bus.result_ch, bus.result); end
    cyc(1);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL multi_ready: got %b expected 1", bus.ready); end
  endtask

  task automatic test_auto;
    bit seen;
    int d0;
    logic [1:0] exp_ch;
    vin[0] = 12'h111;
    vin[1] = 12'h222;
    bus.auto = 1'b1;
    pulse_start(4'b0011);
    for (int i = 0; i < 4; i++) begin
      exp_ch = 2'(i % 2);
      wait_done(40, seen);
      checks++; if (!seen || bus.result_ch !== exp_ch || bus.result !== vin[exp_ch]) begin errors++; $display("FAIL auto_res%0d: got seen=%b ch=%0d res=%h expected ch=%0d res=%h", i, seen, bus.result_ch, bus.result, exp_ch, vin[exp_ch]); end
      if (i == 1) begin
        cyc(1);
        bus.auto = 1'b0;
        checks++; if ({bus.ch_sel, bus.sample_and_hold} !== 3'b001) begin errors++; $display("FAIL auto_wrap: got ch=%0d sh=%b expected ch=0 sh=1", bus.ch_sel, bus.sample_and_hold); end
      end
    end
    cyc(1);
    d0 = done_cnt;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL auto_stop_ready: got %b expected 1", bus.ready); end
    cyc(40);
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL auto_stop_done: got %0d dones expected %0d", done_cnt, d0); end
  endtask

  task automatic test_abort;
    int d0;
    d0 = done_cnt;
    vin[0] = 12'h5A5;
    pulse_start(4'b0001);
    cyc(20);
    checks++; if (bus.dac !== 12'h5A0) begin errors++; $display("FAIL abort_bit5_dac: got %h expected 5a0", bus.dac); end
    cyc(1);
    bus.en = 1'b0;
    cyc(1);
    checks++; if ({bus.pwr_gate, bus.busy, bus.done, bus.ready, bus.dac_rst} !== 5'b00001) begin errors++; $display("FAIL abort_off: got %b expected 00001", {bus.pwr_gate, bus.busy, bus.done, bus.ready, bus.dac_rst}); end
    checks++; if ({bus.result_ch, bus.result} !== 14'h1222) begin errors++; $display("FAIL abort_result: got ch=%0d res=%h expected ch=1 res=222", bus.result_ch, bus.result); end
    cyc(5);
    bus.en = 1'b1;
    cyc(16);
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL abort_early_ready: got %b expected 0", bus.ready); end
    cyc(1);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", bus.ready); end
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL abort_no_done: got %0d dones expected %0d", done_cnt, d0); end
  endtask

  task automatic test_ignore;
    bit seen;
    int d0;
    d0 = done_cnt;
    pulse_start(4'b0000);
    checks++; if ({bus.ready, bus.busy} !== 2'b10) begin errors++; $display("FAIL zero_mask_state: got %b expected 10", {bus.ready, bus.busy}); end
    cyc(40);
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL zero_mask_done: got %0d dones expected %0d", done_cnt, d0); end
    vin[0] = 12'h0F0;
    vin[2] = 12'h707;
    pulse_start(4'b0001);
    cyc(5);
    pulse_start(4'b0100);
    checks++; if ({bus.busy, bus.ch_sel} !== 3'b100) begin errors++; $display("FAIL busy_start_state: got %b expected 100", {bus.busy, bus.ch_sel}); end
    wait_done(40, seen);
    checks++; if (!seen || {bus.result_ch, bus.result} !== 14'h00F0) begin errors++; $display("FAIL busy_start_res: got seen=%b ch=%0d res=%h expected ch=0 res=0f0", seen, bus.result_ch, bus.result); end
    cyc(40);
    checks++; if (done_cnt !== d0 + 1 || bus.ready !== 1'b1) begin errors++; $display("FAIL busy_start_done: got %0d dones ready=%b expected %0d ready=1", done_cnt, bus.ready, d0 + 1); end
  endtask

  task automatic test_reset_mid;
    int d0;
    d0 = done_cnt;
    vin[0] = 12'h456;
    pulse_start(4'b0001);
    cyc(12);
    reset = 1'b1;
    #1;
    checks++; if ({bus.pwr_gate, bus.busy, bus.done, bus.ready, bus.dac_rst} !== 5'b00001) begin errors++; $display("FAIL midreset_ctrl: got %b expected 00001", {bus.pwr_gate, bus.busy, bus.done, bus.ready, bus.dac_rst}); end
    checks++; if ({bus.result, bus.dac} !== 24'h000000) begin errors++; $display("FAIL midreset_data: got res=%h dac=%h expected 000", bus.result, bus.dac); end
    cyc(3);
    reset = 1'b0;
    cyc(40);
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL midreset_done: got %0d dones expected %0d", done_cnt, d0); end
  endtask

  initial begin
    bus.en      = 1'b0;
    bus.start   = 1'b0;
    bus.auto    = 1'b0;
    bus.ch_mask = '0;
    for (int i = 0; i < N; i++) vin[i] = '0;
    test_reset;
    test_powerup;
    test_single;
    test_boundary;
    test_multi;
    test_auto;
    test_abort;
    test_ignore;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
